// File: rtl/fsm_mon_pkg.sv
// fsm_mon_pkg: shared state encoding and default parameters for the sequence monitor.
package fsm_mon_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    TRACK  = 2'b01,
    ALARM  = 2'b10,
    LOCKED = 2'b11
  } state_e;
  localparam int DEF_W           = 3;
  localparam int DEF_NCODES      = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_LOCK_THRESH = 3;
  localparam int DEF_CNT_MAX     = (1 << DEF_CNT_W) - 1;
endpackage

// File: rtl/seq_step_check.sv
// seq_step_check: flags an out-of-range code or a step that is neither hold nor +1 mod NCODES.
module seq_step_check #(
  parameter int W      = 3,
  parameter int NCODES = 4
) (
  input  logic [W-1:0] last_good,
  input  logic [W-1:0] obs_code,
  input  logic         have_ref,
  output logic         is_violation
);
  logic [W-1:0] nxt;
  logic         bad_code;
  always_comb begin
    bad_code     = {1'b0, obs_code} >= (W+1)'(NCODES);
    nxt          = (last_good == W'(NCODES - 1)) ? '0 : last_good + 1'b1;
    is_violation = bad_code | (have_ref & (obs_code != last_good) & (obs_code != nxt));
  end
endmodule

// File: rtl/fsm_seq_monitor.sv
// fsm_seq_monitor: checks the sequencer walk, counts violations and locks fail-secure past a threshold.
module fsm_seq_monitor
  import fsm_mon_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int NCODES      = DEF_NCODES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_THRESH = DEF_LOCK_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             obs_valid,
  input  logic [W-1:0]     obs_code,
  input  logic             clr_alarm,
  output logic             alarm,
  output logic             locked,
  output logic [CNT_W-1:0] err_count,
  output logic [W-1:0]     err_code,
  output logic [W-1:0]     last_good
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LOCK_T  = CNT_W'(LOCK_THRESH);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] err_count_q, err_count_d, cnt_inc;
  logic [W-1:0]     err_code_q, err_code_d, last_good_q, last_good_d;
  logic             step_viol, viol, go_lock;
  seq_step_check #(.W(W), .NCODES(NCODES)) u_chk (
    .last_good    (last_good_q),
    .obs_code     (obs_code),
    .have_ref     (state_q == TRACK || state_q == ALARM),
    .is_violation (step_viol)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      err_count_q <= '0;
      err_code_q  <= '0;
      last_good_q <= '0;
    end else begin
      state_q     <= state_d;
      err_count_q <= err_count_d;
      err_code_q  <= err_code_d;
      last_good_q <= last_good_d;
    end
  end
  // A violation always beats clr_alarm in the same cycle; LOCKED ignores all inputs.
  always_comb begin
    viol        = obs_valid & step_viol & (state_q != LOCKED);
    cnt_inc     = (err_count_q == CNT_MAX) ? err_count_q : err_count_q + 1'b1;
    go_lock     = cnt_inc >= LOCK_T;
    case (state_q)
      IDLE, TRACK: state_d = viol ? (go_lock ? LOCKED : ALARM) : (obs_valid ? TRACK : state_q);
      ALARM:       state_d = viol ? (go_lock ? LOCKED : ALARM) : (clr_alarm ? IDLE : ALARM);
      default:     state_d = LOCKED;
    endcase
    err_count_d = viol ? cnt_inc : err_count_q;
    err_code_d  = viol ? obs_code : err_code_q;
    last_good_d = (obs_valid & ~viol & (state_q != LOCKED)) ? obs_code : last_good_q;
  end
  always_comb begin
    alarm     = (state_q == ALARM) || (state_q == LOCKED);
    locked    = state_q == LOCKED;
    err_count = err_count_q;
    err_code  = err_code_q;
    last_good = last_good_q;
  end
endmodule

// File: tb/tb_fsm_seq_monitor.sv
// tb_fsm_seq_monitor: table-driven vectors plus hand sequences, checked through an expectation queue.
module tb_fsm_seq_monitor;
  typedef struct packed {
    logic       al;
    logic       lk;
    logic [7:0] cnt;
    logic [2:0] ec;
    logic [2:0] lg;
  } out_t;
  typedef struct packed {
    logic       r;
    logic       v;
    logic [2:0] c;
    logic       clr;
    out_t       e;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       obs_valid = 1'b0;
  logic [2:0] obs_code = '0;
  logic       clr_alarm = 1'b0;
  logic       alarm, locked;
  logic [7:0] err_count;
  logic [2:0] err_code, last_good;
  int         checks = 0;
  int         errors = 0;
  out_t       sb[$];
  vec_t       tbl[$];
  fsm_seq_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .obs_valid (obs_valid),
    .obs_code  (obs_code),
    .clr_alarm (clr_alarm),
    .alarm     (alarm),
    .locked    (locked),
    .err_count (err_count),
    .err_code  (err_code),
    .last_good (last_good)
  );
  always #5 clk = ~clk;
  function automatic vec_t vec(logic r, logic v, logic [2:0] c, logic clr,
                               logic al, logic lk, logic [7:0] cnt, logic [2:0] ec, logic [2:0] lg);
    vec_t x;
    x.r = r; x.v = v; x.c = c; x.clr = clr;
    x.e = '{al: al, lk: lk, cnt: cnt, ec: ec, lg: lg};
    return x;
  endfunction
  task automatic compare(string name, out_t exp);
    out_t act;
    act = '{al: alarm, lk: locked, cnt: err_count, ec: err_code, lg: last_good};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got alarm=%0b locked=%0b err_count=%0d err_code=%0d last_good=%0d, need alarm=%0b locked=%0b err_count=%0d err_code=%0d last_good=%0d",
               name, act.al, act.lk, act.cnt, act.ec, act.lg, exp.al, exp.lk, exp.cnt, exp.ec, exp.lg);
    end
  endtask
  task automatic step(string name, vec_t x);
    @(negedge clk);
    rst = x.r; obs_valid = x.v; obs_code = x.c; clr_alarm = x.clr;
    sb.push_back(x.e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got none, need one entry", name);
    end else compare(name, sb.pop_front());
  endtask
  initial begin
    tbl.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(vec(0, 1, 2, 0, 0, 0, 0, 0, 2));
    tbl.push_back(vec(0, 1, 3, 0, 0, 0, 0, 0, 3));
    tbl.push_back(vec(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(vec(0, 1, 3, 0, 1, 0, 1, 3, 1));
    tbl.push_back(vec(0, 0, 0, 1, 0, 0, 1, 3, 1));
    tbl.push_back(vec(0, 1, 2, 0, 0, 0, 1, 3, 2));
    tbl.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 5, 0, 1, 0, 1, 5, 0));
    tbl.push_back(vec(0, 1, 0, 0, 1, 0, 1, 5, 0));
    tbl.push_back(vec(0, 1, 2, 1, 1, 0, 2, 2, 0));
    tbl.push_back(vec(0, 1, 3, 0, 1, 1, 3, 3, 0));
    tbl.push_back(vec(0, 0, 0, 1, 1, 1, 3, 3, 0));
    tbl.push_back(vec(0, 1, 1, 1, 1, 1, 3, 3, 0));
    tbl.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 2, 0, 1, 0, 1, 2, 0));
    tbl.push_back(vec(0, 1, 3, 0, 1, 0, 2, 3, 0));
    tbl.push_back(vec(0, 1, 7, 0, 1, 1, 3, 7, 0));
    tbl.push_back(vec(0, 0, 0, 1, 1, 1, 3, 7, 0));
    tbl.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);
    step("seed0", vec(0, 1, 0, 0, 0, 0, 0, 0, 0));
    step("seed1", vec(0, 1, 1, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 10; i++) step($sformatf("idle_garbage%0d", i), vec(0, 0, 6, 0, 0, 0, 0, 0, 1));
    step("skip_to3", vec(0, 1, 3, 0, 1, 0, 1, 3, 1));
    for (int i = 0; i < 2; i++) step($sformatf("alarm_hold%0d", i), vec(0, 0, 6, 0, 1, 0, 1, 3, 1));
    step("clr_invalid", vec(0, 0, 6, 1, 0, 0, 1, 3, 1));
    step("reseed1", vec(0, 1, 1, 0, 0, 0, 1, 3, 1));
    step("skip_again", vec(0, 1, 3, 0, 1, 0, 2, 3, 1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    compare("async_rst", '{al: 1'b0, lk: 1'b0, cnt: 8'd0, ec: 3'd0, lg: 3'd0});
    step("post_rst_seed", vec(0, 1, 2, 0, 0, 0, 0, 0, 2));
    step("post_rst_step", vec(0, 1, 3, 0, 0, 0, 0, 0, 3));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
